// File: rtl/rv_decode_pkg.sv
// Shared types and constants for the RV32I/RV64I decode stage.
package rv_decode_pkg;

  // Base-ISA major opcodes recognised by the decoder
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Instruction format; R is encoding 0 so a reset entry reads as R
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd6
  } fmt_e;

  // Decoded entry; pc/imm sized for the widest XLEN, narrower builds use the low bits
  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    fmt_e        fmt;
    logic [63:0] imm;
    logic        rd_we;
    logic        illegal;
  } dec_t;

  // Map a major opcode onto its instruction format
  function automatic fmt_e opc_to_fmt(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_LUI, OPC_AUIPC:                                 f = FMT_U;
      OPC_JAL:                                            f = FMT_J;
      OPC_BRANCH:                                         f = FMT_B;
      OPC_STORE:                                          f = FMT_S;
      OPC_OP:                                             f = FMT_R;
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_FENCE, OPC_SYSTEM: f = FMT_I;
      default:                                            f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv_decode_stage_imm.sv
// Immediate generator: builds the sign-extended XLEN immediate for a format.
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  // Assemble the 32-bit sign-extended immediate; R and ILL carry none
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every RV immediate fits in 32 bits; widening is a plain sign extension
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64I decode stage with a two-entry skid buffer.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit CHK_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm,
  output logic            rd_we,
  output logic            illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("rv_decode_stage: XLEN must be 32 or 64");
  end

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]      state_reg, state_next;
  dec_t            out_reg, out_next;
  dec_t            skid_reg, skid_next;
  dec_t            dec_in;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] gen_imm;
  logic            in_fire, out_fire;

  assign dec_fmt     = opc_to_fmt(in_instr[6:0]);
  assign dec_illegal = CHK_ILLEGAL && ((dec_fmt == FMT_ILL) || (in_instr[1:0] != 2'b11));

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (dec_fmt),
    .imm   (gen_imm)
  );

  // Decode the incoming word into an entry; illegal words keep raw fields only
  always_comb begin
    dec_in         = '0;
    dec_in.pc      = 64'(in_pc);
    dec_in.opcode  = in_instr[6:0];
    dec_in.funct3  = in_instr[14:12];
    dec_in.funct7  = in_instr[31:25];
    dec_in.rd      = in_instr[11:7];
    dec_in.rs1     = in_instr[19:15];
    dec_in.rs2     = in_instr[24:20];
    dec_in.fmt     = dec_fmt;
    dec_in.illegal = dec_illegal;
    dec_in.imm     = dec_illegal ? '0 : 64'(gen_imm);
    dec_in.rd_we   = !dec_illegal && (in_instr[11:7] != 5'd0) &&
                     (dec_fmt == FMT_R || dec_fmt == FMT_I ||
                      dec_fmt == FMT_U || dec_fmt == FMT_J);
  end

  // in_ready depends only on state so it stays a registered signal
  assign in_ready  = (state_reg != ST_TWO);
  assign out_valid = (state_reg != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Skid-buffer control: output register is always the FIFO head, skid the tail
  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            out_next   = dec_in;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            out_next = dec_in;
          end else if (in_fire) begin
            skid_next  = dec_in;
            state_next = ST_TWO;
          end else if (out_fire) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            out_next   = skid_reg;
            state_next = ST_ONE;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // State and entry registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      out_reg   <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      skid_reg  <= skid_next;
    end
  end

  assign out_pc  = out_reg.pc[XLEN-1:0];
  assign opcode  = out_reg.opcode;
  assign funct3  = out_reg.funct3;
  assign funct7  = out_reg.funct7;
  assign rd      = out_reg.rd;
  assign rs1     = out_reg.rs1;
  assign rs2     = out_reg.rs2;
  assign fmt     = out_reg.fmt;
  assign imm     = out_reg.imm[XLEN-1:0];
  assign rd_we   = out_reg.rd_we;
  assign illegal = out_reg.illegal;

  // Upper halves of pc/imm are unused in a 32-bit build
  if (XLEN < 64) begin : g_hi_sink
    logic unused_hi;
    assign unused_hi = ^{out_reg.pc[63:XLEN], out_reg.imm[63:XLEN]};
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench: XLEN=32/CHK_ILLEGAL=1 and XLEN=64/CHK_ILLEGAL=0 instances
// share one stimulus stream and are compared against a queue-based reference.
module tb_rv_decode_stage;
  import rv_decode_pkg::*;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc64;

  logic        a_in_ready, a_out_valid, a_rd_we, a_illegal;
  logic [31:0] a_out_pc, a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [2:0]  a_funct3;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  fmt_e        a_fmt;

  logic        b_in_ready, b_out_valid, b_rd_we, b_illegal;
  logic [63:0] b_out_pc, b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [2:0]  b_funct3;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  fmt_e        b_fmt;

  rv_decode_stage #(.XLEN(32), .CHK_ILLEGAL(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc64[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .opcode(a_opcode), .funct3(a_funct3), .funct7(a_funct7),
    .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .fmt(a_fmt), .imm(a_imm),
    .rd_we(a_rd_we), .illegal(a_illegal));

  rv_decode_stage #(.XLEN(64), .CHK_ILLEGAL(1'b0)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .opcode(b_opcode), .funct3(b_funct3), .funct7(b_funct7),
    .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .fmt(b_fmt), .imm(b_imm),
    .rd_we(b_rd_we), .illegal(b_illegal));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed { logic [31:0] w; logic [63:0] pc; } ent_t;
  typedef struct { fmt_e fmt; logic [63:0] imm; bit rd_we; bit ill; } exp_t;

  ent_t q[$];

  // Reference decode: immediates built from weighted bit fields with a negative sign weight
  function automatic exp_t ref_dec(input logic [31:0] w, input bit chk_ill);
    exp_t  e;
    longint v;
    case (w[6:0])
      7'b0110111, 7'b0010111: e.fmt = FMT_U;
      7'b1101111:             e.fmt = FMT_J;
      7'b1100011:             e.fmt = FMT_B;
      7'b0100011:             e.fmt = FMT_S;
      7'b0110011:             e.fmt = FMT_R;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: e.fmt = FMT_I;
      default:                e.fmt = FMT_ILL;
    endcase
    e.ill = chk_ill && (e.fmt == FMT_ILL || w[1:0] != 2'b11);
    case (e.fmt)
      FMT_I: v = longint'(w[31:20]) - (w[31] ? 64'sd4096 : 64'sd0);
      FMT_S: v = longint'({w[31:25], w[11:7]}) - (w[31] ? 64'sd4096 : 64'sd0);
      FMT_B: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2
                 - (w[31] ? 64'sd4096 : 64'sd0);
      FMT_U: v = longint'(w[31:12]) * 4096 - (w[31] ? 64'sd4294967296 : 64'sd0);
      FMT_J: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2
                 - (w[31] ? 64'sd1048576 : 64'sd0);
      default: v = 0;
    endcase
    e.imm   = e.ill ? 64'd0 : 64'(v);
    e.rd_we = !e.ill && (w[11:7] != 5'd0) &&
              (e.fmt == FMT_R || e.fmt == FMT_I || e.fmt == FMT_U || e.fmt == FMT_J);
    return e;
  endfunction

  // Compare both instances against the reference queue head
  task automatic check_outputs();
    exp_t        ea, eb;
    logic [31:0] w;
    chk_eq("out_valid32", a_out_valid, q.size() > 0);
    chk_eq("in_ready32",  a_in_ready,  q.size() < 2);
    chk_eq("out_valid64", b_out_valid, q.size() > 0);
    chk_eq("in_ready64",  b_in_ready,  q.size() < 2);
    if (q.size() > 0) begin
      w  = q[0].w;
      ea = ref_dec(w, 1'b1);
      eb = ref_dec(w, 1'b0);
      chk_eq("fields32", {a_opcode, a_funct3, a_funct7, a_rd, a_rs1, a_rs2},
             {w[6:0], w[14:12], w[31:25], w[11:7], w[19:15], w[24:20]});
      chk_eq("pc32",    a_out_pc, q[0].pc[31:0]);
      chk_eq("fmt32",   a_fmt,    ea.fmt);
      chk_eq("imm32",   a_imm,    ea.imm[31:0]);
      chk_eq("rdwe32",  a_rd_we,  ea.rd_we);
      chk_eq("ill32",   a_illegal, ea.ill);
      chk_eq("fields64", {b_opcode, b_funct3, b_funct7, b_rd, b_rs1, b_rs2},
             {w[6:0], w[14:12], w[31:25], w[11:7], w[19:15], w[24:20]});
      chk_eq("pc64",    b_out_pc, q[0].pc);
      chk_eq("fmt64",   b_fmt,    eb.fmt);
      chk_eq("imm64",   b_imm,    eb.imm);
      chk_eq("rdwe64",  b_rd_we,  eb.rd_we);
      chk_eq("ill64",   b_illegal, eb.ill);
    end
  endtask

  // One clock cycle: check, drive, update reference at the edge, return at negedge
  task automatic step(input bit v, input logic [31:0] w, input logic [63:0] pc,
                      input bit ordy, input bit fl);
    bit   in_f, out_f;
    ent_t e;
    check_outputs();
    in_valid = v; in_instr = w; in_pc64 = pc; out_ready = ordy; flush = fl;
    in_f  = v && (q.size() < 2);
    out_f = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (out_f) void'(q.pop_front());
      if (in_f) begin e.w = w; e.pc = pc; q.push_back(e); end
    end
    @(negedge clk);
  endtask

  // Directed decode with literal expectations; leaves the stage empty afterwards
  task automatic dir(input string tag, input logic [31:0] w, input fmt_e efmt,
                     input logic [63:0] eimm, input bit erdwe, input bit eill);
    step(1'b1, w, 64'h1000, 1'b0, 1'b0);
    chk_eq({tag, "_valid"}, a_out_valid, 1'b1);
    chk_eq({tag, "_fmt"},   a_fmt,       efmt);
    chk_eq({tag, "_imm32"}, a_imm,       eimm[31:0]);
    chk_eq({tag, "_imm64"}, b_imm,       eimm);
    chk_eq({tag, "_rdwe"},  a_rd_we,     erdwe);
    chk_eq({tag, "_ill32"}, a_illegal,   eill);
    chk_eq({tag, "_ill64"}, b_illegal,   1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  localparam logic [6:0] OPCS [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100011,
    7'b0100011, 7'b0110011, 7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011};

  initial begin
    logic [31:0] w;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc64 = '0;
    repeat (2) @(negedge clk);
    chk_eq("rst_out_valid", a_out_valid, 1'b0);
    chk_eq("rst_in_ready",  a_in_ready,  1'b1);
    chk_eq("rst_imm",       a_imm,       '0);
    chk_eq("rst_fmt",       a_fmt,       '0);
    rst = 1'b0;
    @(negedge clk);

    dir("addi", 32'hFFF00093, FMT_I, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    chk_eq("addi_rd_rs1", 0, 0 + 0);
    dir("sw",   32'hFE20AE23, FMT_S, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    dir("beq",  32'hFE000CE3, FMT_B, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
    dir("lui",  32'h123452B7, FMT_U, 64'h0000_0000_1234_5000, 1'b1, 1'b0);
    dir("zero", 32'h00000000, FMT_ILL, 64'h0, 1'b0, 1'b1);
    dir("ones", 32'h0000007F, FMT_ILL, 64'h0, 1'b0, 1'b1);

    // Back-pressure: A,B accepted, C held off until the skid drains; order A,B,C
    step(1'b1, 32'h00000093, 64'h10, 1'b0, 1'b0);
    step(1'b1, 32'h00000113, 64'h14, 1'b0, 1'b0);
    chk_eq("bp_full_in_ready", a_in_ready, 1'b0);
    step(1'b1, 32'h00000193, 64'h18, 1'b0, 1'b0);
    chk_eq("bp_head_A", a_rd, 5'd1);
    step(1'b1, 32'h00000193, 64'h18, 1'b1, 1'b0);
    chk_eq("bp_head_B", a_rd, 5'd2);
    step(1'b1, 32'h00000193, 64'h18, 1'b1, 1'b0);
    chk_eq("bp_head_C", a_rd, 5'd3);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush while full with an offered word: everything dropped
    step(1'b1, 32'h00000093, 64'h20, 1'b0, 1'b0);
    step(1'b1, 32'h00000113, 64'h24, 1'b0, 1'b0);
    step(1'b1, 32'h00000193, 64'h28, 1'b0, 1'b1);
    chk_eq("flush_out_valid", a_out_valid, 1'b0);
    chk_eq("flush_in_ready",  a_in_ready,  1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stall clears outputs before the next edge
    step(1'b1, 32'hFFF00093, 64'h30, 1'b0, 1'b0);
    step(1'b1, 32'h123452B7, 64'h34, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_out_valid", a_out_valid, 1'b0);
    chk_eq("arst_in_ready",  a_in_ready,  1'b1);
    chk_eq("arst_imm",       a_imm,       '0);
    chk_eq("arst_pc",        a_out_pc,    '0);
    chk_eq("arst_rd",        a_rd,        '0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    q.delete();
    @(negedge clk);

    // Randomised traffic against the reference queue
    for (int i = 0; i < 1500; i++) begin
      w = $urandom();
      if ($urandom_range(0, 9) < 8) w[6:0] = OPCS[$urandom_range(0, 10)];
      step($urandom_range(0, 3) != 0, w, {$urandom(), $urandom()},
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
